// File: rtl/counter.sv
// Loadable up-counter with count enable and a registered wrap indicator.
// Build with COUNTER_STICKY_OVF_EN defined to make overflow_detect a sticky flag.
module counter #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             EN,
  input  logic             RST,
  input  logic             CLK,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] load_in,
  output logic [WIDTH-1:0] c_out,
  output logic             overflow_detect
);

`ifdef COUNTER_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // Wrap happens on the edge that increments an all-ones count back to zero.
  logic wrap;
  assign wrap = &c_out;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      c_out           <= RESET_VALUE;
      overflow_detect <= 1'b0;
    end else if (LOAD) begin
      c_out           <= load_in;
      overflow_detect <= 1'b0;
    end else if (EN) begin
      c_out           <= c_out + 1'b1;
      overflow_detect <= wrap | (STICKY & overflow_detect);
    end else begin
      overflow_detect <= STICKY & overflow_detect;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter (WIDTH=4, RESET_VALUE=0); inputs change and
// outputs are sampled on the falling clock edge.
module tb_counter;
  logic       CLK;
  logic       RST;
  logic       EN;
  logic       LOAD;
  logic [3:0] load_in;
  logic [3:0] c_out;
  logic       overflow_detect;

  int checks   = 0;
  int failures = 0;

`ifdef COUNTER_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  counter #(.WIDTH(4), .RESET_VALUE(4'd0)) dut (
    .EN(EN),
    .RST(RST),
    .CLK(CLK),
    .LOAD(LOAD),
    .load_in(load_in),
    .c_out(c_out),
    .overflow_detect(overflow_detect)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b0; EN = 1'b0; LOAD = 1'b0; load_in = 4'd0;
    tick();
    checks++;
    if (c_out !== 4'd0) begin
      failures++; $display("FAIL reset_c_out got=%0d exp=0", c_out);
    end
    checks++;
    if (overflow_detect !== 1'b0) begin
      failures++; $display("FAIL reset_ovf got=%b exp=0", overflow_detect);
    end
    RST = 1'b1;
  endtask

  task automatic test_load_hold;
    LOAD = 1'b1; load_in = 4'b0110;
    tick();
    tick();
    checks++;
    if (c_out !== 4'd6) begin
      failures++; $display("FAIL load_c_out got=%0d exp=6", c_out);
    end
    LOAD = 1'b0; EN = 1'b0; load_in = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (c_out !== 4'd6 || overflow_detect !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d got=%0d/%b exp=6/0", i, c_out, overflow_detect);
      end
    end
  endtask

  task automatic test_count_wrap;
    logic [3:0] exp_c;
    logic       exp_o;
    logic       seen_wrap;
    exp_c = 4'd6;
    seen_wrap = 1'b0;
    EN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_c = exp_c + 4'd1;
      if (exp_c == 4'd0) seen_wrap = 1'b1;
      exp_o = (exp_c == 4'd0) || (STICKY && seen_wrap);
      checks++;
      if (c_out !== exp_c || overflow_detect !== exp_o) begin
        failures++;
        $display("FAIL count_%0d got=%0d/%b exp=%0d/%b", i, c_out, overflow_detect, exp_c, exp_o);
      end
    end
    EN = 1'b0;
    tick();
    checks++;
    if (c_out !== 4'd2 || overflow_detect !== STICKY) begin
      failures++;
      $display("FAIL hold_after_wrap got=%0d/%b exp=2/%b", c_out, overflow_detect, STICKY);
    end
  endtask

  task automatic test_load_priority;
    LOAD = 1'b1; load_in = 4'd15; EN = 1'b0;
    tick();
    checks++;
    if (c_out !== 4'd15 || overflow_detect !== 1'b0) begin
      failures++; $display("FAIL load15 got=%0d/%b exp=15/0", c_out, overflow_detect);
    end
    LOAD = 1'b1; EN = 1'b1; load_in = 4'd3;
    tick();
    checks++;
    if (c_out !== 4'd3 || overflow_detect !== 1'b0) begin
      failures++; $display("FAIL load_over_en got=%0d/%b exp=3/0", c_out, overflow_detect);
    end
    LOAD = 1'b0; EN = 1'b0;
  endtask

  task automatic test_reset_midcount;
    LOAD = 1'b1; load_in = 4'd8; EN = 1'b0;
    tick();
    LOAD = 1'b0; EN = 1'b1;
    tick();
    checks++;
    if (c_out !== 4'd9) begin
      failures++; $display("FAIL pre_reset got=%0d exp=9", c_out);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (c_out !== 4'd0 || overflow_detect !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%0d/%b exp=0/0", c_out, overflow_detect);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (c_out !== 4'd1 || overflow_detect !== 1'b0) begin
      failures++; $display("FAIL resume got=%0d/%b exp=1/0", c_out, overflow_detect);
    end
    // Reset must also clear an overflow that is currently visible.
    LOAD = 1'b1; load_in = 4'd15; EN = 1'b0;
    tick();
    LOAD = 1'b0; EN = 1'b1;
    tick();
    checks++;
    if (c_out !== 4'd0 || overflow_detect !== 1'b1) begin
      failures++; $display("FAIL wrap_before_reset got=%0d/%b exp=0/1", c_out, overflow_detect);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (c_out !== 4'd0 || overflow_detect !== 1'b0) begin
      failures++; $display("FAIL reset_clears_ovf got=%0d/%b exp=0/0", c_out, overflow_detect);
    end
    RST = 1'b1; EN = 1'b0;
  endtask

  task automatic test_en_toggle;
    logic [3:0] exp_seq [3];
    logic       en_seq  [3];
    exp_seq[0] = 4'd5; exp_seq[1] = 4'd5; exp_seq[2] = 4'd6;
    en_seq[0]  = 1'b1; en_seq[1]  = 1'b0; en_seq[2]  = 1'b1;
    LOAD = 1'b1; load_in = 4'd4; EN = 1'b0;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      EN = en_seq[i];
      tick();
      checks++;
      if (c_out !== exp_seq[i] || overflow_detect !== 1'b0) begin
        failures++;
        $display("FAIL en_toggle_%0d got=%0d/%b exp=%0d/0", i, c_out, overflow_detect, exp_seq[i]);
      end
    end
    EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_count_wrap();
    test_load_priority();
    test_reset_midcount();
    test_en_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Synchronous up-counter with parallel load, count enable and a wrap-around (overflow) indicator.
- General-purpose leaf block used as an event/cycle counter or loadable timer inside larger datapaths.
- Everything is registered on a single clock; there is no combinational path from inputs to outputs.

Parameters:
- WIDTH, 4, counter and load-data width in bits (legal range 2..32).
- RESET_VALUE, 0, value taken by c_out on reset (WIDTH bits, must be < 2^WIDTH).

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous reset, active-low (0 = reset).
- EN  input  1  count enable, active-high.
- LOAD  input  1  parallel load strobe, active-high.
- load_in  input  WIDTH  value loaded into the counter when LOAD=1.
- c_out  output  WIDTH  current count (register output).
- overflow_detect  output  1  one-cycle wrap pulse (register output).
- Positional port order is fixed: EN, RST, CLK, LOAD, load_in, c_out, overflow_detect.

Behaviour:
- All state is evaluated at the rising edge of CLK. Priority order is RST, then LOAD, then EN, then hold.
- Reset: RST=0 gives c_out=RESET_VALUE and overflow_detect=0. Reset is synchronous only; RST has no effect between edges. Outputs are undefined before the first reset edge.
- Load: RST=1 and LOAD=1 gives c_out=load_in and overflow_detect=0. EN is ignored while LOAD=1.
- Count: RST=1, LOAD=0, EN=1 gives c_out=(c_out+1) mod 2^WIDTH.
  - If the pre-edge c_out was all ones, overflow_detect=1 for exactly the cycle in which c_out shows 0.
  - Otherwise overflow_detect=0.
- Hold: RST=1, LOAD=0, EN=0 keeps c_out unchanged and sets overflow_detect=0.
- Latency: every input takes effect in c_out/overflow_detect one edge after it is sampled.
- Wrap-around is modular; there is no saturation in the default build.
- Simultaneous events:
  - RST=0 overrides LOAD and EN.
  - LOAD=1 with c_out all ones and EN=1 loads the value and produces no overflow pulse.
- Reset mid-count clears c_out and any pending or visible overflow pulse on that edge.
- EN/LOAD with X or Z values are not required to be handled; the environment drives them to known levels once RST has been deasserted.

Optional Feature:
- Macro COUNTER_STICKY_OVF_EN.
- Defined: overflow_detect becomes a sticky flag.
  - It is set on a wrap as described above.
  - It stays 1 through subsequent counting and holding.
  - It is cleared only by RST=0 or by LOAD=1.
- Undefined: overflow_detect is the one-cycle pulse described in Behaviour.

Test Plan:
- RST=0 for one edge with EN=0, LOAD=0 -> c_out=0, overflow_detect=0.
- After reset, LOAD=1 with load_in=4'b0110 for two edges, then LOAD=0, EN=0 -> c_out=6 and held for 3 further edges.
- From c_out=6, EN=1 for 12 edges -> c_out steps 7..15, then 0, 1, 2. overflow_detect=1 only on the edge where c_out becomes 0. With COUNTER_STICKY_OVF_EN defined it stays 1 afterwards.
- c_out=15 with EN=1 and LOAD=1, load_in=3 -> c_out=3, overflow_detect=0.
- While counting with EN=1 at c_out=9, drive RST=0 for one edge -> c_out=0, overflow_detect=0. With RST=1 and EN=1, counting resumes at 1.
- EN toggled 1,0,1 starting at c_out=4 -> c_out goes 5, 5, 6. No overflow pulse.
